// File: rtl/vector_mask_packer.sv
// vector_mask_packer: gathers per-beat compare masks from the vector compare
// unit into a packed VLEN/8-bit mask (element i at bit i) and hands the result
// to register-file writeback over a valid/ready handshake.
//
// Build option: define TAIL_ONES_EN to fill mask bits at index >= vl with 1
// (tail-agnostic). When it is left undefined, tail bits are 0.

// Per-bit accumulator update. Each mask bit decides on its own whether the
// current beat covers it, so the top level has no dynamic bit indexing.
module vector_mask_packer_lane #(
    parameter int IDX   = 0,
    parameter int PTR_W = 8
) (
    input  logic             init_i,   // start accepted: load the tail value
    input  logic             tail_i,   // tail fill value for bits >= vl
    input  logic             beat_i,   // beat handshake this cycle
    input  logic [PTR_W-1:0] ptr_i,    // first element index of this beat
    input  logic [PTR_W-1:0] k_i,      // elements carried by this beat
    input  logic [PTR_W-1:0] vl_i,     // active element count
    input  logic [7:0]       mask_i,   // compare results of this beat
    input  logic             acc_q_i,
    output logic             acc_d_o
);
    localparam logic [PTR_W-1:0] POS = PTR_W'(IDX);

    logic [PTR_W-1:0] off;
    logic             hit;

    // Take the compare bit only if this beat covers the element and it is below vl
    always_comb begin
        off     = POS - ptr_i;
        hit     = beat_i && (POS >= ptr_i) && (off < k_i) && (POS < vl_i);
        acc_d_o = acc_q_i;
        if (init_i)
            acc_d_o = tail_i & (POS >= vl_i);
        else if (hit)
            acc_d_o = mask_i[off[2:0]];
    end
endmodule

module vector_mask_packer #(
    parameter  int VLEN       = 512,
    parameter  int DATA_WIDTH = 64,
    localparam int MASK_WIDTH = VLEN / 8,
    localparam int VL_W       = $clog2(MASK_WIDTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            sew,
    input  logic [VL_W-1:0]       vl,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_mask,
    output logic                  mask_valid,
    input  logic                  mask_ready,
    output logic [MASK_WIDTH-1:0] mask_data
);
    // Elements per beat at the narrowest SEW (8-bit elements).
    localparam int KMAX = DATA_WIDTH / 8;
    // Pointer needs headroom for one beat past the last active element.
    localparam int PTR_W = VL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_OUTPUT
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [1:0]            sew_q, sew_d;
    logic [VL_W-1:0]       vl_q, vl_d;
    logic [MASK_WIDTH-1:0] acc_q, acc_d;

    logic [VL_W-1:0]  vl_clamp;
    logic [PTR_W-1:0] k_cur;
    logic [PTR_W-1:0] vl_lane;
    logic             start_go;
    logic             beat;
    logic             last_beat;
    logic             tail_fill;

`ifdef TAIL_ONES_EN
    assign tail_fill = 1'b1;
`else
    assign tail_fill = 1'b0;
`endif

    // Request decode; vl beyond the register is clamped so no bit past the top is written
    always_comb begin
        vl_clamp  = (vl > VL_W'(MASK_WIDTH)) ? VL_W'(MASK_WIDTH) : vl;
        k_cur     = PTR_W'(KMAX) >> sew_q;
        start_go  = (state_q == ST_IDLE) && start;
        beat      = (state_q == ST_COLLECT) && in_valid;
        last_beat = (ptr_q + k_cur) >= PTR_W'(vl_q);
        // At start the lanes need the incoming vl for the tail fill
        vl_lane   = start_go ? PTR_W'(vl_clamp) : PTR_W'(vl_q);
    end

    // FSM next state plus latched operation parameters
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sew_d   = sew_q;
        vl_d    = vl_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sew_d   = sew;
                    vl_d    = vl_clamp;
                    ptr_d   = '0;
                    state_d = (vl_clamp == '0) ? ST_OUTPUT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (in_valid) begin
                    ptr_d = ptr_q + k_cur;
                    if (last_beat)
                        state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (mask_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sew_q   <= '0;
            vl_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sew_q   <= sew_d;
            vl_q    <= vl_d;
        end
    end

    for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_lane
        vector_mask_packer_lane #(
            .IDX   (i),
            .PTR_W (PTR_W)
        ) u_lane (
            .init_i  (start_go),
            .tail_i  (tail_fill),
            .beat_i  (beat),
            .ptr_i   (ptr_q),
            .k_i     (k_cur),
            .vl_i    (vl_lane),
            .mask_i  (in_mask),
            .acc_q_i (acc_q[i]),
            .acc_d_o (acc_d[i])
        );
    end

    // Mask accumulator
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    // Outputs are pure state decode so reset drives them low immediately
    always_comb begin
        busy       = (state_q != ST_IDLE);
        in_ready   = (state_q == ST_COLLECT);
        mask_valid = (state_q == ST_OUTPUT);
        mask_data  = (state_q == ST_OUTPUT) ? acc_q : '0;
    end
endmodule

// File: tb/tb_vector_mask_packer.sv
// Directed bench for vector_mask_packer (VLEN=512 -> 64-bit mask).
// Expected masks are hand-computed; tail fill follows TAIL_ONES_EN.
module tb_vector_mask_packer;
    logic        clock;
    logic        reset_n;
    logic        start;
    logic [1:0]  sew;
    logic [6:0]  vl;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_mask;
    logic        mask_valid;
    logic        mask_ready;
    logic [63:0] mask_data;

    int n_chk = 0;
    int n_err = 0;

    vector_mask_packer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .sew        (sew),
        .vl         (vl),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mask    (in_mask),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .mask_data  (mask_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [63:0] tail(input int v);
`ifdef TAIL_ONES_EN
        logic [63:0] ones;
        ones = '1;
        return (v >= 64) ? 64'd0 : (ones << v);
`else
        return 64'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic go(input logic [1:0] s, input logic [6:0] v);
        sew   = s;
        vl    = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] m);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_mask  = m;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("beat_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic finish_out();
        mask_ready = 1'b1;
        tick();
        mask_ready = 1'b0;
        chk("done_valid", {63'd0, mask_valid}, 64'd0);
        chk("done_busy",  {63'd0, busy},       64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [7:0]  b;
        reset_n    = 1'b0;
        start      = 1'b0;
        sew        = 2'd0;
        vl         = 7'd0;
        in_valid   = 1'b0;
        in_mask    = 8'd0;
        mask_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy",  {63'd0, busy},       64'd0);
        chk("rst_rdy",   {63'd0, in_ready},   64'd0);
        chk("rst_valid", {63'd0, mask_valid}, 64'd0);
        chk("rst_data",  mask_data,           64'd0);
        reset_n = 1'b1;
        tick();

        // 1: sew=8, vl=16
        go(2'd0, 7'd16);
        chk("t1_busy", {63'd0, busy},     64'd1);
        chk("t1_rdy",  {63'd0, in_ready}, 64'd1);
        send(8'hA5);
        chk("t1_mid_valid", {63'd0, mask_valid}, 64'd0);
        send(8'h3C);
        chk("t1_latency", {63'd0, mask_valid}, 64'd1);
        chk("t1_rdy_out", {63'd0, in_ready},   64'd0);
        chk("t1_data",    mask_data, 64'h3CA5 | tail(16));
        finish_out();

        // 2: sew=64, vl=3, upper in_mask bits ignored
        go(2'd3, 7'd3);
        send(8'hFF);
        send(8'h00);
        chk("t2_mid_valid", {63'd0, mask_valid}, 64'd0);
        send(8'hFF);
        chk("t2_valid", {63'd0, mask_valid}, 64'd1);
        chk("t2_data",  mask_data, 64'h5 | tail(3));
        finish_out();

        // 3: sew=32, vl=5, straddling beat writes only its head
        go(2'd2, 7'd5);
        send(8'h03);
        send(8'h02);
        send(8'h03);
        chk("t3_valid", {63'd0, mask_valid}, 64'd1);
        chk("t3_data",  mask_data, 64'h1B | tail(5));
        finish_out();

        // 4: vl=0 goes straight to OUTPUT
        go(2'd0, 7'd0);
        chk("t4_valid", {63'd0, mask_valid}, 64'd1);
        chk("t4_data",  mask_data, tail(0));
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            chk("t4_rdy", {63'd0, in_ready}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        finish_out();

        // 5: backpressure on output, start ignored meanwhile
        go(2'd0, 7'd8);
        send(8'h5A);
        exp = 64'h5A | tail(8);
        for (int c = 0; c < 5; c++) begin
            chk("t5_valid", {63'd0, mask_valid}, 64'd1);
            chk("t5_data",  mask_data, exp);
            if (c == 2) begin
                sew   = 2'd3;
                vl    = 7'd0;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        chk("t5_hold", mask_data, exp);
        finish_out();

        // 6: asynchronous reset mid-collection, then clean repack
        go(2'd1, 7'd16);
        send(8'h0F);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_busy",  {63'd0, busy},       64'd0);
        chk("t6_rdy",   {63'd0, in_ready},   64'd0);
        chk("t6_valid", {63'd0, mask_valid}, 64'd0);
        chk("t6_data",  mask_data,           64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        go(2'd1, 7'd16);
        send(8'h01);
        send(8'h02);
        send(8'h04);
        send(8'h08);
        chk("t6_valid2", {63'd0, mask_valid}, 64'd1);
        chk("t6_data2",  mask_data, 64'h8421 | tail(16));
        finish_out();

        // 7: vl above 64 clamps to full register, 8 beats
        go(2'd0, 7'd100);
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            b = 8'h11 * i[7:0] + 8'h3;
            exp[8*i +: 8] = b;
            if (i == 7) chk("t7_pre_valid", {63'd0, mask_valid}, 64'd0);
            send(b);
        end
        chk("t7_valid", {63'd0, mask_valid}, 64'd1);
        chk("t7_data",  mask_data, exp);
        finish_out();

        // 8: sew=16, vl=6: second beat straddles vl
        go(2'd1, 7'd6);
        send(8'hFF);
        send(8'hFF);
        chk("t8_valid", {63'd0, mask_valid}, 64'd1);
        chk("t8_data",  mask_data, 64'h3F | tail(6));
        finish_out();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
